// File: rtl/spi_cfg_regfile.sv
// Addressed SPI (mode 0, MSB first) configuration register file with a shadow bank,
// atomic commit to the live cfg outputs and burst auto-increment addressing.
module spi_cfg_regfile #(
    parameter int                W        = 8,
    parameter int                NREG     = 8,
    parameter logic [NREG*W-1:0] DEFAULTS = '0
) (
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [NREG*W-1:0] cfg,
    output logic              commit_tgl
);
    localparam int         AW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int         RXW      = (W > 1) ? W - 1 : 1;
    localparam logic [5:0] LAST_BIT = 6'(W - 1);
    localparam logic [6:0] NREG_L   = 7'(NREG);

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;
    localparam logic [1:0] OP_THRU   = 2'b11;

    typedef enum logic [1:0] {S_CMD, S_READ, S_WRITE, S_IDLE} state_t;

    state_t         state_q;
    logic [5:0]     cnt_q;
    logic [5:0]     addr_q;
    logic [7:0]     cmd_q;
    logic [RXW-1:0] rx_q;
    logic [W-1:0]   tx_q;
    logic           miso_q;
    logic [W-1:0]   shadow_q [NREG];
    logic [W-1:0]   active_q [NREG];
    logic           tgl_q;

    logic           frame_rst;
    logic [7:0]     cmd_d;
    logic [W-1:0]   word_d;
    logic [5:0]     addr_d;
    logic           word_done;
    logic           commit_stb;
    logic           wr_stb;
    logic           thru;
    logic           addr_ok;

    // NOTE: CSn high aborts the frame asynchronously, so it joins rst as a reset
    // for the frame-level state only; the register banks survive it.
    assign frame_rst  = rst | spi_csn;
    assign cmd_d      = {cmd_q[6:0], spi_mosi};
    assign addr_d     = addr_q + 6'd1;
    assign word_done  = (state_q == S_READ || state_q == S_WRITE) && cnt_q == LAST_BIT;
    assign commit_stb = state_q == S_CMD && cnt_q == 6'd7 && cmd_d[7:6] == OP_COMMIT;
    assign wr_stb     = state_q == S_WRITE && word_done;
    assign thru       = cmd_q[7:6] == OP_THRU;
    assign addr_ok    = {1'b0, addr_q} < NREG_L;

    generate
        if (W > 1) begin : g_word
            assign word_d = {rx_q, spi_mosi};
        end else begin : g_word1
            assign word_d = spi_mosi;
        end
    endgenerate

    function automatic logic [W-1:0] rd_word(input logic [5:0] a);
        rd_word = ({1'b0, a} < NREG_L) ? active_q[a[AW-1:0]] : '0;
    endfunction

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge spi_clk or posedge frame_rst) begin
        if (frame_rst) begin
            state_q <= S_CMD;
            cnt_q   <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
        end else begin
            case (state_q)
                S_CMD: begin
                    cmd_q <= cmd_d;
                    if (cnt_q == 6'd7) begin
                        cnt_q  <= '0;
                        addr_q <= cmd_d[5:0];
                        case (cmd_d[7:6])
                            OP_READ: begin
                                state_q <= S_READ;
                                tx_q    <= rd_word(cmd_d[5:0]);
                            end
                            OP_WRITE, OP_THRU: state_q <= S_WRITE;
                            default:           state_q <= S_IDLE;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_READ, S_WRITE: begin
                    rx_q <= word_d[RXW-1:0];
                    if (word_done) begin
                        cnt_q  <= '0;
                        addr_q <= addr_d;
                        tx_q   <= rd_word(addr_d);
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                        tx_q  <= tx_q << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Launch on the falling edge so the master samples a settled bit on the next rise.
    always_ff @(negedge spi_clk or posedge frame_rst) begin
        if (frame_rst) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= (state_q == S_READ) ? tx_q[W-1] : 1'b0;
        end
    end

    // NOTE: the banks are real configuration registers, not RAM, so they take the
    // DEFAULTS image on reset rather than being left uninitialised.
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                shadow_q[k] <= DEFAULTS[k*W +: W];
                active_q[k] <= DEFAULTS[k*W +: W];
            end
            tgl_q <= 1'b0;
        end else begin
            if (commit_stb) begin
                for (int k = 0; k < NREG; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
            if (wr_stb && addr_ok) begin
                shadow_q[addr_q[AW-1:0]] <= word_d;
                if (thru) begin
                    active_q[addr_q[AW-1:0]] <= word_d;
                end
            end
            if (commit_stb || (wr_stb && thru)) begin
                tgl_q <= ~tgl_q;
            end
        end
    end

    generate
        for (genvar k = 0; k < NREG; k++) begin : g_cfg
            assign cfg[k*W +: W] = active_q[k];
        end
    endgenerate

    assign spi_miso   = miso_q;
    assign commit_tgl = tgl_q;

endmodule
